// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] REG_ZERO = '0;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency producers; a set beats a clear on the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (clr_en[j]) busy_nxt[clr_addr[j*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: the newly issued producer is younger than any retiring write.
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rbusy[i] = busy[raddr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clearing sweep and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                set_busy,
  input  logic [AW-1:0]       set_addr
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  state_e          state;
  logic [AW-1:0]   sweep_cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic            run;
  logic            set_ok;
  logic [NWR-1:0]  wr_ok;
  logic [NRD-1:0]  sb_busy;

  assign run    = (state == RUN);
  assign ready  = run;
  assign set_ok = run && set_busy && (set_addr != ZERO_A);

  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_ok[j] = run && we[j] && (waddr[j*AW +: AW] != ZERO_A);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= AW'(1);
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == AW'(NREGS - 1)) state <= RUN;
    end
  end

  // NOTE: storage has no reset so it maps onto plain RAM/flops; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[sweep_cnt] <= '0;
    end else begin
      // Ascending loop: the highest-indexed port's assignment is the one that lands.
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && (raddr[i*AW +: AW] != ZERO_A)) begin
        rdata[i*XLEN +: XLEN] = mem[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]))
            rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
        end
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .set_en   (set_ok),
    .set_addr (set_addr),
    .raddr    (raddr),
    .rbusy    (sb_busy)
  );

  assign rbusy = sb_busy & {NRD{run}};

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset sweep, write/read vectors, scoreboard and bypass corners.
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ready;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                set_busy;
  logic [AW-1:0]       set_addr;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .set_busy (set_busy),
    .set_addr (set_addr)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        sb;
    logic [4:0]  sa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  exp_t expq [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    set_busy = 1'b0;
    set_addr = '0;
  endtask

  task automatic push_exp(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    expq.push_back(e);
  endtask

  // Counts edges until ready; with probe set, also tries illegal traffic mid-sweep.
  task automatic wait_ready(input string name, input bit probe);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (probe && cyc == 10) begin
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h0000DEAD};
        set_busy = 1'b1; set_addr = 5'd6; raddr = {5'd6, 5'd5};
      end
      if (probe && cyc == 15) begin
        #3;
        check({name, " sweep rdata0"}, rdata[31:0], 32'h0);
        check({name, " sweep rbusy"}, 32'(rbusy), 32'h0);
      end
      if (probe && cyc == 20) idle();
    end
    check({name, " cycles to ready"}, 32'(cyc), 32'd31);
  endtask

  initial begin
    exp_t got;

    vecs[0] = '{2'b11, 5'd3,  32'h11,       5'd3, 32'h22,       1'b0, 5'd0,  5'd3,  5'd0,  32'h22,       32'h0,        2'b00};
    vecs[1] = '{2'b11, 5'd0,  32'hFFFFFFFF, 5'd4, 32'h44,       1'b0, 5'd0,  5'd0,  5'd4,  32'h0,        32'h44,       2'b00};
    vecs[2] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,        1'b1, 5'd7,  5'd7,  5'd4,  32'h0,        32'h44,       2'b01};
    vecs[3] = '{2'b10, 5'd0,  32'h0,        5'd7, 32'h77,       1'b1, 5'd7,  5'd7,  5'd7,  32'h77,       32'h77,       2'b11};
    vecs[4] = '{2'b01, 5'd7,  32'h78,       5'd0, 32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'h78,       32'h22,       2'b00};
    vecs[5] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
    vecs[6] = '{2'b11, 5'd5,  32'h55,       5'd6, 32'h66,       1'b1, 5'd5,  5'd5,  5'd6,  32'h55,       32'h66,       2'b01};
    vecs[7] = '{2'b11, 5'd31, 32'hFFFFFFFF, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 32'hA5A5A5A5, 2'b00};
    vecs[8] = '{2'b10, 5'd0,  32'h0,        5'd5, 32'h5,        1'b1, 5'd31, 5'd5,  5'd31, 32'h5,        32'hFFFFFFFF, 2'b10};
    vecs[9] = '{2'b01, 5'd2,  32'h2,        5'd3, 32'hBAD,      1'b0, 5'd0,  5'd2,  5'd3,  32'h2,        32'h22,       2'b00};

    idle();
    raddr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'h0);
    check("reset rbusy", 32'(rbusy), 32'h0);
    rst_n = 1'b1;
    wait_ready("release", 1'b1);

    raddr = {5'd6, 5'd5};
    #3;
    check("x5 after sweep", rdata[31:0], 32'h0);
    check("busy x6 after sweep", 32'(rbusy), 32'h0);

    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk); #1;
      we       = vecs[k].we;
      waddr    = {vecs[k].wa1, vecs[k].wa0};
      wdata    = {vecs[k].wd1, vecs[k].wd0};
      set_busy = vecs[k].sb;
      set_addr = vecs[k].sa;
      raddr    = {vecs[k].ra1, vecs[k].ra0};
      push_exp($sformatf("vec%0d rdata0", k), vecs[k].e0);
      push_exp($sformatf("vec%0d rdata1", k), vecs[k].e1);
      push_exp($sformatf("vec%0d rbusy", k), {30'h0, vecs[k].eb});
      @(posedge clk); #1;
      idle();
      #3;
      got = expq.pop_front(); check(got.name, rdata[31:0], got.val);
      got = expq.pop_front(); check(got.name, rdata[63:32], got.val);
      got = expq.pop_front(); check(got.name, 32'(rbusy), got.val);
    end

    // Same-cycle write/read of x9.
    @(posedge clk); #1;
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
    @(posedge clk); #1;
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'hABCD, 32'h0}; raddr = {5'd9, 5'd0};
    #3;
`ifdef REGFILE_BYPASS_EN
    check("bypass same cycle", rdata[63:32], 32'hABCD);
`else
    check("no bypass same cycle", rdata[63:32], 32'h99);
`endif
    @(posedge clk); #1;
    idle();
    #3;
    check("x9 next cycle", rdata[63:32], 32'hABCD);

    // Mid-sweep reset with a busy register outstanding.
    @(posedge clk); #1;
    set_busy = 1'b1; set_addr = 5'd4;
    @(posedge clk); #1;
    idle();
    raddr = {5'd3, 5'd4};
    #3;
    check("busy x4 set", 32'(rbusy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async reset ready", 32'(ready), 32'h0);
    check("async reset rbusy", 32'(rbusy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid-sweep reset ready", 32'(ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("restart", 1'b0);
    #3;
    check("busy x4 after restart", 32'(rbusy), 32'h0);
    check("x4 after restart", rdata[31:0], 32'h0);
    check("x3 after restart", rdata[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
